shift_cmd_sequencer: RTL and testbench
======================================

SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: a command is present.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept a command.
REQ-005 SHALL have port in_op, input, 3 bits: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-006 SHALL have port in_amt, input, 4 bits: total shift or rotate amount, 0-15.
REQ-007 SHALL have port in_data, input, 8 bits: operand.
REQ-008 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_data, output, 8 bits: the result.
REQ-011 SHALL have port out_err, output, 1 bit: the command used a reserved op.
REQ-012 SHALL have port busy, output, 1 bit: the FSM is in RUN.

Function
REQ-013 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL accept a command when in_valid and in_ready are both high on a clock edge, and SHALL latch op, amount and data at that edge.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-016 SHALL go from IDLE to RUN on accept, and SHALL stay in IDLE otherwise.
REQ-017 In each RUN cycle, SHALL apply one pass of k = min(remaining,7) to the working register, then subtract k from remaining.
REQ-018 SHALL go from RUN to DONE after the pass that makes remaining reach 0.
REQ-019 A command with amount 0 SHALL still take exactly one RUN cycle, with k = 0.
REQ-020 The number of RUN cycles SHALL be max(1, ceil(amt/7)); out_valid SHALL rise on the edge that ends the last RUN cycle.
REQ-021 SLL and SRL SHALL zero-fill; SRA SHALL fill with the latched bit 7; ROL and ROR SHALL wrap mod 8.
REQ-022 Total amounts of 8 or more SHALL saturate naturally: SLL/SRL give 0x00, SRA gives 0x00 or 0xFF.
REQ-023 A reserved op SHALL pass the data through unchanged and set out_err; it SHALL use the same RUN timing as a valid op.
REQ-024 In DONE, out_valid, out_data and out_err SHALL hold stable until out_ready is high.
REQ-025 In DONE with out_ready and no new accept, the FSM SHALL return to IDLE and out_valid SHALL fall.
REQ-026 In DONE with out_ready and in_valid both high, the result SHALL retire and the new command SHALL be accepted on the same edge, moving directly to RUN.
REQ-027 in_* values SHALL be ignored outside an accept edge.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state IDLE, out_valid 0, out_data 0x00, out_err 0, busy 0, remaining 0.
REQ-029 A reset during RUN or DONE SHALL discard the command, and no result SHALL be produced.
REQ-030 in_ready SHALL be 1 on the first edge after reset release.

Configuration
REQ-031 With macro SHIFT_SEQ_FLAGS_EN defined, SHALL add output out_zero (out_data==0) and output out_neg (out_data[7]); both SHALL be registered with out_data, reset to 0, and held in DONE.
REQ-032 With SHIFT_SEQ_FLAGS_EN undefined, these ports and their registers SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-033 Package shift_seq_pkg SHALL hold the op encoding enum, the FSM state enum, MAX_PASS=7, DATA_W=8 and AMT_W=4.
REQ-034 SHALL contain one sub-module, shift_pass_core: combinational; inputs op, k (3 bits) and data (8 bits); output the single-pass result.

Verification
REQ-035 SLL, in_data 0x01, amount 9 -> 2 RUN cycles, out_data 0x00, out_err 0.
REQ-036 ROR, 0x81, amount 1 -> 1 RUN cycle, out_data 0xC0; ROL, 0x81, amount 15 -> 3 RUN cycles, out_data 0xC0.
REQ-037 SRA, 0x80, amount 15 -> out_data 0xFF; SRL, 0x80, amount 0 -> 1 RUN cycle, out_data 0x80.
REQ-038 op 110, in_data 0x5A, amount 3 -> out_data 0x5A, out_err 1.
REQ-039 Hold out_ready low 5 cycles in DONE -> out_valid and out_data stable and in_ready 0; then raise out_ready with in_valid high -> retire and new accept on the same edge.
REQ-040 Pulse rst_n low during the 2nd RUN cycle of an amount-14 command -> out_valid never rises, all outputs 0, in_ready 1 after release.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift/rotate command sequencer.
package shift_seq_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned AMT_W    = 4;
    localparam int unsigned MAX_PASS = 7;

    typedef enum logic [2:0] {
        OpSll = 3'b000,
        OpSrl = 3'b001,
        OpSra = 3'b010,
        OpRol = 3'b011,
        OpRor = 3'b100
    } shift_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OpRor;
    endfunction

endpackage

// File: rtl/shift_pass_core.sv
// Single combinational shift/rotate pass of up to MAX_PASS bit positions.
module shift_pass_core
    import shift_seq_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [2:0]        k,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] rol_w;
    logic [2*DATA_W-1:0] ror_w;

    always_comb begin
        dbl   = {data, data};
        rol_w = dbl << k;
        ror_w = dbl >> k;
        case (op)
            OpSll:   result = data << k;
            OpSrl:   result = data >> k;
            OpSra:   result = $signed(data) >>> k;
            OpRol:   result = rol_w[2*DATA_W-1:DATA_W];
            OpRor:   result = ror_w[DATA_W-1:0];
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Shift/rotate command sequencer: splits the amount into passes of at most 7 bits.
// Optional zero/negative result flags are enabled with SHIFT_SEQ_FLAGS_EN.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
`ifdef SHIFT_SEQ_FLAGS_EN
    output logic              out_zero,
    output logic              out_neg,
`endif
    output logic              busy
);

    localparam logic [AMT_W-1:0] MaxPassAmt = AMT_W'(MAX_PASS);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_err_q, out_err_d;
    logic                busy_q, busy_d;
`ifdef SHIFT_SEQ_FLAGS_EN
    logic                zero_q, zero_d;
    logic                neg_q, neg_d;
`endif

    logic [2:0]          pass_k;
    logic [DATA_W-1:0]   pass_result;
    logic [AMT_W-1:0]    rem_next;
    logic                accept;

    assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept   = in_valid & in_ready;
    assign pass_k   = (rem_q > MaxPassAmt) ? MaxPassAmt[2:0] : rem_q[2:0];
    assign rem_next = rem_q - {1'b0, pass_k};

    shift_pass_core u_pass (
        .op     (op_q),
        .k      (pass_k),
        .data   (work_q),
        .result (pass_result)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        work_d      = work_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
`ifdef SHIFT_SEQ_FLAGS_EN
        zero_d      = zero_q;
        neg_d       = neg_q;
`endif
        case (state_q)
            StRun: begin
                work_d = pass_result;
                rem_d  = rem_next;
                // An amount of 0 still makes one k=0 pass, so rem_next is 0 right away.
                if (rem_next == '0) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    out_data_d  = pass_result;
                    out_err_d   = is_reserved(op_q);
`ifdef SHIFT_SEQ_FLAGS_EN
                    zero_d      = (pass_result == '0);
                    neg_d       = pass_result[DATA_W-1];
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Covers both IDLE and the retire-and-accept case in DONE.
        if (accept) begin
            state_d = StRun;
            op_d    = in_op;
            rem_d   = in_amt;
            work_d  = in_data;
        end
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            rem_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHIFT_SEQ_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            busy_q      <= busy_d;
`ifdef SHIFT_SEQ_FLAGS_EN
            zero_q      <= zero_d;
            neg_q       <= neg_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = busy_q;
`ifdef SHIFT_SEQ_FLAGS_EN
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: transaction-level reference model, directed cases, random traffic.
module tb_shift_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] in_op = '0;
    logic [3:0] in_amt = '0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_err;
    logic       busy;
`ifdef SHIFT_SEQ_FLAGS_EN
    logic       out_zero;
    logic       out_neg;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: cycles of RUN still ahead, and whether a result is being presented.
    int         m_left = 0;
    bit         m_has = 1'b0;
    logic [7:0] m_res = '0;
    logic       m_err = 1'b0;
    logic [7:0] p_res = '0;
    logic       p_err = 1'b0;

    shift_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
`ifdef SHIFT_SEQ_FLAGS_EN
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-command result straight from the total amount.
    function automatic void ref_result(input logic [2:0] op, input int amt, input logic [7:0] d,
                                       output logic [7:0] res, output logic err);
        int v;
        int r;
        v   = int'(d);
        err = 1'b0;
        r   = amt % 8;
        case (op)
            3'd0: v = (v << amt) & 255;
            3'd1: v = v >> amt;
            3'd2: for (int i = 0; i < amt; i++) v = (v >> 1) | (d[7] ? 128 : 0);
            3'd3: v = ((v << r) | (v >> (8 - r))) & 255;
            3'd4: v = ((v >> r) | (v << (8 - r))) & 255;
            default: err = 1'b1;
        endcase
        res = v[7:0];
    endfunction

    function automatic int ref_cycles(input int amt);
        return (amt == 0) ? 1 : (amt + 6) / 7;
    endfunction

    // Check the state after the last edge, then predict the next edge from the stable inputs.
    always @(negedge clk or negedge rst_n) begin : cmp
        logic mr;
        logic acc;
        if (!rst_n) begin
            m_left = 0;
            m_has  = 1'b0;
        end else begin
            mr = ((m_left == 0) && !m_has) || (m_has && out_ready);
            if (chk_en) begin
                check("in_ready", {31'd0, in_ready}, {31'd0, mr});
                check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
                check("out_valid", {31'd0, out_valid}, {31'd0, m_has});
                if (m_has) begin
                    check("out_data", {24'd0, out_data}, {24'd0, m_res});
                    check("out_err", {31'd0, out_err}, {31'd0, m_err});
`ifdef SHIFT_SEQ_FLAGS_EN
                    check("out_zero", {31'd0, out_zero}, {31'd0, (m_res == 8'h00)});
                    check("out_neg", {31'd0, out_neg}, {31'd0, m_res[7]});
`endif
                end
            end
            acc = in_valid && mr;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_has = 1'b1;
                    m_res = p_res;
                    m_err = p_err;
                end
            end else if (m_has && out_ready) begin
                m_has = 1'b0;
            end
            if (acc) begin
                ref_result(in_op, int'(in_amt), in_data, p_res, p_err);
                m_left = ref_cycles(int'(in_amt));
            end
        end
    end

    task automatic retire();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] amt,
                           input logic [7:0] d, input logic [7:0] exp_d, input logic exp_e,
                           input int exp_cyc, input bit do_retire);
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_op     = op;
        in_amt    = amt;
        in_data   = d;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_amt   = 4'($urandom);
        in_data  = 8'($urandom);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else if (busy) cnt++;
        end
        check({tag, " done"}, {31'd0, got}, 32'd1);
        check({tag, " run_cycles"}, cnt, exp_cyc);
        check({tag, " data"}, {24'd0, out_data}, {24'd0, exp_d});
        check({tag, " err"}, {31'd0, out_err}, {31'd0, exp_e});
        if (do_retire) retire();
    endtask

    initial begin : main
        logic [7:0] r;
        logic       e;
        bit         rose;

        ref_result(3'd3, 15, 8'h81, r, e);
        check("model rol15", {24'd0, r}, 32'h0000_00C0);
        ref_result(3'd2, 3, 8'hA0, r, e);
        check("model sra3", {24'd0, r}, 32'h0000_00F4);
        ref_result(3'd7, 2, 8'h3C, r, e);
        check("model reserved", {23'd0, e, r}, 32'h0000_013C);
        check("model cycles14", ref_cycles(14), 2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", {24'd0, out_data}, 32'd0);
        check("reset out_err", {31'd0, out_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);
        chk_en = 1'b1;

        run_cmd("sll 01 by 9", 3'd0, 4'd9, 8'h01, 8'h00, 1'b0, 2, 1'b1);
        run_cmd("ror 81 by 1", 3'd4, 4'd1, 8'h81, 8'hC0, 1'b0, 1, 1'b1);
        run_cmd("rol 81 by 15", 3'd3, 4'd15, 8'h81, 8'hC0, 1'b0, 3, 1'b1);
        run_cmd("sra 80 by 15", 3'd2, 4'd15, 8'h80, 8'hFF, 1'b0, 3, 1'b1);
        run_cmd("srl 80 by 0", 3'd1, 4'd0, 8'h80, 8'h80, 1'b0, 1, 1'b1);
        run_cmd("op6 5a by 3", 3'd6, 4'd3, 8'h5A, 8'h5A, 1'b1, 1, 1'b1);

        // Backpressure in DONE, then retire and accept on the same edge.
        run_cmd("hold ror", 3'd4, 4'd1, 8'h81, 8'hC0, 1'b0, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold out_data", {24'd0, out_data}, 32'h0000_00C0);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_amt    = 4'd3;
        in_data   = 8'h11;
        @(negedge clk);
        check("b2b in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("b2b result valid", {31'd0, out_valid}, 32'd1);
        check("b2b result data", {24'd0, out_data}, 32'h0000_0088);
        retire();

        // Reset pulse in the second RUN cycle of a 14-bit shift.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_amt   = 4'd14;
        in_data  = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_data", {24'd0, out_data}, 32'd0);
        check("rst out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready after release", {31'd0, in_ready}, 32'd1);
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        check("rst no result", {31'd0, rose}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4))
                                                    : 3'($urandom_range(5, 7));
            in_amt    = 4'($urandom);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
